// File: rtl/roberto_tx_serial.sv
// Asynchronous serial transmitter: 7 data bits, LSB first, 1 stop bit; odd parity when ROBERTO_TX_PARITY_EN is defined (7O1), else 7N1.
// Request-to-pronto latency 1+FW*DIV cycles; partida is only sampled in IDLE, so a held request cannot duplicate a frame.
module roberto_tx_serial #(
    parameter int DIV   = 434,
    parameter int CNT_W = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados,
    output logic       saida_serial,
    output logic       pronto,
    output logic       ocupado,
    output logic [2:0] db_estado
);

`ifdef ROBERTO_TX_PARITY_EN
    localparam int FW = 10;
`else
    localparam int FW = 9;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TX    = 2'b01,
        ST_FINAL = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [3:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              saida_q, saida_d;
    logic              pronto_q, pronto_d;
    logic              ocupado_q, ocupado_d;
    logic [FW-1:0]     new_frame;

`ifdef ROBERTO_TX_PARITY_EN
    assign new_frame = {1'b1, ~^dados, dados, 1'b0};
`else
    assign new_frame = {1'b1, dados, 1'b0};
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (partida) begin
                    frame_d = new_frame;
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    frame_d = {1'b1, frame_q[FW-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d   = 4'd0;
                        state_d = ST_FINAL;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINAL: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                frame_d = '1;
                bit_d   = 4'd0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        saida_d   = (state_d == ST_TX) ? frame_d[0] : 1'b1;
        pronto_d  = (state_d == ST_FINAL);
        ocupado_d = (state_d == ST_TX) || (state_d == ST_FINAL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '1;
            bit_q     <= 4'd0;
            cnt_q     <= '0;
            saida_q   <= 1'b1;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            saida_q   <= saida_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_IDLE:  db_estado = 3'b000;
            ST_TX:    db_estado = 3'b001;
            ST_FINAL: db_estado = 3'b010;
            default:  db_estado = 3'b111;
        endcase
    end

    assign saida_serial = saida_q;
    assign pronto       = pronto_q;
    assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_roberto_tx_serial.sv
// Bench for roberto_tx_serial at DIV=4: table-driven frames, held-request and mid-frame corner cases, and randomized characters.
module tb_roberto_tx_serial;
    localparam int DIV = 4;
`ifdef ROBERTO_TX_PARITY_EN
    localparam int FW = 10;
`else
    localparam int FW = 9;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       partida;
    logic [6:0] dados;
    logic       saida_serial;
    logic       pronto;
    logic       ocupado;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;

    roberto_tx_serial #(.DIV(DIV), .CNT_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .dados        (dados),
        .saida_serial (saida_serial),
        .pronto       (pronto),
        .ocupado      (ocupado),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] d;
        logic       par;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [9:0] hand_frame(input logic [6:0] d, input logic par);
`ifdef ROBERTO_TX_PARITY_EN
        return {1'b1, par, d, 1'b0};
`else
        return {par, 1'b1, d, 1'b0};
`endif
    endfunction

    // Reference: list the line bits in transmission order from counted ones.
    function automatic logic [9:0] ref_frame(input logic [6:0] d);
        logic [9:0] b;
        int ones;
        b = '0;
        ones = $countones(d);
        b[0] = 1'b0;
        for (int i = 0; i < 7; i++) b[i+1] = d[i];
        if (FW == 10) begin
            b[8] = (ones % 2 == 0);
            b[9] = 1'b1;
        end else begin
            b[8] = 1'b1;
        end
        return b;
    endfunction

    task automatic check_out(input string nm, input int j, input logic e_line,
                             input logic e_pr, input logic e_oc, input logic [2:0] e_st);
        checks++;
        if (saida_serial !== e_line) begin
            errors++;
            $display("FAIL %s saida_serial j=%0d got %b expected %b", nm, j, saida_serial, e_line);
        end
        checks++;
        if (pronto !== e_pr) begin
            errors++;
            $display("FAIL %s pronto j=%0d got %b expected %b", nm, j, pronto, e_pr);
        end
        checks++;
        if (ocupado !== e_oc) begin
            errors++;
            $display("FAIL %s ocupado j=%0d got %b expected %b", nm, j, ocupado, e_oc);
        end
        checks++;
        if (db_estado !== e_st) begin
            errors++;
            $display("FAIL %s db_estado j=%0d got %b expected %b", nm, j, db_estado, e_st);
        end
    endtask

    // Called mid-cycle; the next rising edge accepts the request (edge k).
    // Sample j observes cycle k+j; the run ends after the idle cycle k+FW*DIV+2.
    task automatic run_frame(input logic [6:0] d, input logic [9:0] bits, input logic hold,
                             input int chg_at, input logic [6:0] chg_d, input string nm);
        logic e_line, e_pr, e_oc;
        logic [2:0] e_st;
        dados   = d;
        partida = 1'b1;
        for (int j = 1; j <= FW*DIV + 2; j++) begin
            @(negedge clock);
            if (j <= FW*DIV) begin
                e_line = bits[(j-1)/DIV];
                e_pr = 1'b0; e_oc = 1'b1; e_st = 3'b001;
            end else if (j == FW*DIV + 1) begin
                e_line = 1'b1; e_pr = 1'b1; e_oc = 1'b1; e_st = 3'b010;
            end else begin
                e_line = 1'b1; e_pr = 1'b0; e_oc = 1'b0; e_st = 3'b000;
            end
            check_out(nm, j, e_line, e_pr, e_oc, e_st);
            if (j == 1 && !hold) partida = 1'b0;
            if (j == chg_at) dados = chg_d;
        end
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            check_out(nm, j, 1'b1, 1'b0, 1'b0, 3'b000);
        end
    endtask

    initial begin
        logic [6:0] rd;
        logic       rh;
        logic       prev_hold;
        int         gap;

        tbl[0] = '{7'h41, 1'b1};
        tbl[1] = '{7'h7F, 1'b0};
        tbl[2] = '{7'h30, 1'b1};
        tbl[3] = '{7'h00, 1'b1};
        tbl[4] = '{7'h55, 1'b1};
        tbl[5] = '{7'h2A, 1'b0};
        tbl[6] = '{7'h01, 1'b0};

        reset   = 1'b1;
        partida = 1'b0;
        dados   = 7'h00;
        repeat (2) @(negedge clock);
        check_out("reset", 0, 1'b1, 1'b0, 1'b0, 3'b000);
        reset = 1'b0;
        idle_cycles(20, "idle");

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].d, hand_frame(tbl[i].d, tbl[i].par), 1'b0, 0, 7'h00,
                      $sformatf("table%0d", i));

        // Held request: one frame per FW*DIV+2 cycles, nothing started in FINAL.
        run_frame(7'h7F, hand_frame(7'h7F, 1'b0), 1'b1, 0, 7'h00, "held0");
        run_frame(7'h7F, hand_frame(7'h7F, 1'b0), 1'b1, 0, 7'h00, "held1");
        run_frame(7'h7F, hand_frame(7'h7F, 1'b0), 1'b0, 0, 7'h00, "held2");
        idle_cycles(3, "held_idle");

        run_frame(7'h30, hand_frame(7'h30, 1'b1), 1'b0, 5, 7'h31, "dados_change");

        // Reset mid-frame at cycle k+15.
        dados   = 7'h41;
        partida = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clock);
            if (j == 1) partida = 1'b0;
        end
        check_out("pre_abort", 15, 1'b0, 1'b0, 1'b1, 3'b001);
        reset = 1'b1;
        @(negedge clock);
        check_out("abort", 16, 1'b1, 1'b0, 1'b0, 3'b000);
        reset = 1'b0;
        idle_cycles(50, "after_abort");

        prev_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd  = 7'($urandom_range(0, 127));
            rh  = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            gap = prev_hold ? 0 : $urandom_range(0, 3);
            if (gap > 0) idle_cycles(gap, "rand_gap");
            run_frame(rd, ref_frame(rd), rh, 0, 7'h00, $sformatf("rand%0d_%02h", i, rd));
            prev_hold = rh;
        end
        idle_cycles(2, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
